// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply/divide sequencer.
// One shared 34-bit adder serves both shift-add MULT and restoring DIV.
module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

    state_e      state_q;
    logic        div_q;
    logic        neg_q;
    logic [4:0]  cnt_q;
    logic [31:0] m_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] res_q;
    logic        exc_q;
    logic        rdy_q;
    logic        busy_q;

    logic        start;
    logic        start_div;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [33:0] add_x;
    logic [33:0] add_y;
    logic        add_ci;
    logic [33:0] sum;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] res_d;
    logic        exc_d;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign start_div = ~ctrl_MULT;
    assign abs_a     = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign abs_b     = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

    // DIV subtracts the divisor from the shifted partial remainder;
    // MULT adds the multiplicand to the high half when the low bit is set.
    always_comb begin
        add_x  = 34'd0;
        add_y  = 34'd0;
        add_ci = 1'b0;
        if (div_q) begin
            add_x  = {1'b0, acc_q[63:31]};
            add_y  = {2'b11, ~m_q};
            add_ci = 1'b1;
        end else begin
            add_x  = {2'b00, acc_q[63:32]};
            add_y  = {2'b00, (acc_q[0] ? m_q : 32'd0)};
        end
    end

    assign sum = add_x + add_y + {33'd0, add_ci};

    always_comb begin
        acc_d = acc_q;
        if (div_q) begin
            if (!sum[33])
                acc_d = {sum[31:0], acc_q[30:0], 1'b1};
            else
                acc_d = {acc_q[62:0], 1'b0};
        end else begin
            acc_d = {sum[32:0], acc_q[31:1]};
        end
    end

    assign prod_s = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quot_s = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

    // A positive quotient with bit 31 set only arises from 0x80000000 / -1.
    always_comb begin
        res_d = 32'd0;
        exc_d = 1'b0;
        if (div_q) begin
            if (m_q == 32'd0) begin
                res_d = 32'd0;
                exc_d = 1'b1;
            end else begin
                res_d = quot_s;
                exc_d = ~neg_q & acc_q[31];
            end
        end else begin
            res_d = prod_s[31:0];
            exc_d = (prod_s[63:32] != {32{prod_s[31]}});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= 5'd0;
            m_q     <= 32'd0;
            acc_q   <= 64'd0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rdy_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        div_q   <= start_div;
                        neg_q   <= data_operandA[31] ^ data_operandB[31];
                        cnt_q   <= 5'd0;
                        m_q     <= start_div ? abs_b : abs_a;
                        acc_q   <= {32'd0, (start_div ? abs_a : abs_b)};
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_q <= FIX;
                end
                FIX: begin
                    res_q   <= res_d;
                    exc_q   <= exc_d;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq.
// Latency, busy width, results, exceptions, ignored starts, back-to-back, reset abort.
module tb_multdiv_seq;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int tests;
    int failed;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hA5A5_5A5A;
        data_operandB = 32'h0F0F_F0F0;
    endtask

    // Counts edges after the accept edge until ready, bounded at 40.
    task automatic wait_rdy(input int inject, output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (!data_resultRDY && n < 40) begin
            if (inject != 0 && n == inject) begin
                ctrl_DIV = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
            n++;
            if (busy) bc++;
        end
    endtask

    task automatic run_op(input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee,
                          input int inject, input string tag);
        int n;
        int bc;
        start(m, d, a, b);
        wait_rdy(inject, n, bc);
        chk({tag, " latency"}, n, 32'd33);
        chk({tag, " busy cycles"}, bc, 32'd33);
        chk({tag, " result"}, data_result, er);
        chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, ee});
        @(posedge clock);
        #1;
        chk({tag, " rdy falls"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int n;
        int bc;
        int n2;
        int bad;
        int pulses;
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exc", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 0, "mul 7x-6");
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 0, "mul ovf");
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 0, "mul -1x-1");
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, "div -7/2");
        run_op(0, 1, 32'd5, 32'd0, 32'h0, 1, 0, "div by 0");
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div ovf");
        run_op(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 0, "div -100/7");
        run_op(1, 1, 32'd6, 32'd3, 32'd18, 0, 0, "both mult wins");

        run_op(1, 0, 32'd3, 32'd4, 32'd12, 0, 10, "mul ignore div");
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("ignored start no extra rdy", pulses, 32'd0);

        start(1, 0, 32'd3, 32'd4);
        wait_rdy(0, n, bc);
        chk("b2b first latency", n, 32'd33);
        chk("b2b first result", data_result, 32'd12);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        data_operandA = 32'hFFFF_0000;
        data_operandB = 32'h0000_0000;
        chk("b2b busy after DONE start", {31'd0, busy}, 32'd1);
        n2  = 1;
        bad = 0;
        while (!data_resultRDY && n2 < 40) begin
            if (data_result !== 32'd12) bad++;
            @(posedge clock);
            #1;
            n2++;
        end
        chk("b2b ready spacing", n2, 32'd34);
        chk("b2b result held", bad, 32'd0);
        chk("b2b second result", data_result, 32'd14);

        start(1, 0, 32'd5, 32'd5);
        repeat (19) @(posedge clock);
        #1;
        chk("abort busy before reset", {31'd0, busy}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort result", data_result, 32'd0);
        chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("abort no rdy", pulses, 32'd0);

        run_op(1, 1, 32'd6, 32'd3, 32'd18, 0, 0, "post-reset both");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
